score_display_controller: RTL and testbench
===========================================

Name: score_display_controller

Overview:
Sequences conversion of the binary game score into four decimal digits and drives the four HEX seven-segment displays (HEX3..HEX0). It performs an iterative shift-add-3 (double-dabble) conversion, one bit per clock, then latches active-low segment codes. Sits between the score counter in game logic and the board HEX pins.

Parameters:
SCORE_W, 14, width of binary score input; conversion takes SCORE_W shift cycles.
MAX_SCORE, 9999, largest displayable value; anything above is overflow.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
score  input  SCORE_W  unsigned binary score, sampled only when a request is accepted
update  input  1  conversion request, level-sampled each clock
busy  output  1  high while a conversion is in progress (not IDLE)
done  output  1  one-cycle pulse when new HEX values are latched
overflow  output  1  registered; high when the last latched score exceeded MAX_SCORE
hex0  output  7  ones digit segments, active-low, bit order {g,f,e,d,c,b,a}
hex1  output  7  tens digit segments
hex2  output  7  hundreds digit segments
hex3  output  7  thousands digit segments

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous, active-high, and clears all state immediately.
- Reset values: state IDLE, busy=0, done=0, overflow=0, pending=0, hex0..hex3=7'b1000000 (all show "0").
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111.
- States: IDLE, CONVERT, LATCH.
- IDLE:
  - If update=1 or pending=1, accept the request: load shift register with score, clear the 16-bit BCD register, set bit counter=SCORE_W, record ovf_flag=(score>MAX_SCORE), clear pending, go to CONVERT.
- CONVERT, once per clock:
  - Each BCD nibble >=5 gets +3.
  - Then {bcd,shift} shifts left by 1 and the counter decrements.
  - When the counter reaches 1 on this edge (the SCORE_W-th shift), go to LATCH.
- LATCH:
  - If ovf_flag=1, all hex outputs = dash and overflow=1.
  - Otherwise each hex output = code of its BCD nibble and overflow=0.
  - done=1 for this one cycle; go to IDLE.
- Latency: request accepted at edge k; new hex/done visible after edge k+SCORE_W+1, i.e. 15 cycles at default.
- busy is high from the cycle after acceptance through the LATCH cycle.
- Request while busy: update=1 in CONVERT or LATCH sets pending=1; it is not lost. Multiple requests collapse to one. The re-conversion samples score at its own acceptance edge (the IDLE edge after LATCH).
- update held high continuously: back-to-back conversions, one per SCORE_W+2 cycles.
- score changes during CONVERT have no effect.
- hex outputs hold their last latched values at all times except the LATCH edge; no intermediate BCD values are ever visible.
- Nibble >9 after conversion cannot occur for score<=MAX_SCORE. Defensively it decodes to dash.
- Reset mid-conversion: abort immediately to reset values; pending is cleared.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined:
  - At LATCH (non-overflow), hex3/hex2/hex1 show blank for each leading zero digit.
  - hex0 always shows its digit.
  - Reset values become hex0=1000000, hex1..hex3=1111111.
- When undefined: all four digits are always shown, zeros included.

Test Plan:
- Assert reset mid-operation, release -> hex0..hex3=1000000, busy=0, done=0, overflow=0; with LEADING_ZERO_BLANK_EN, hex1..3=1111111.
- score=1234, pulse update -> done after exactly 15 cycles; hex3=1111001, hex2=0100100, hex1=0110000, hex0=0011001; busy high for 15 cycles.
- score=9999 then score=0 -> all hex=0010000, then all hex=1000000 (or blanks above hex0 with macro); overflow=0.
- score=10000 -> all hex=0111111, overflow=1; then score=5 -> overflow=0, hex0=0010010.
- update at 1234, then change score to 42 and pulse update at cycle 5 of conversion -> first done shows 1234; second done, 16 cycles later (15-cycle latency plus the 1-cycle IDLE acceptance), shows 0042.
- Assert reset at cycle 7 of conversion -> outputs return to reset values at once; no done pulse; no stale pending conversion after release.

Source files
------------

// File: rtl/score_display_controller.sv
// ============================================================================
//  Module   : score_display_controller
//  Function : Serial double-dabble conversion of the score into four BCD digits,
//             driving four active-low seven-segment displays.
//             Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module score_display_controller #(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               update,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3
);

    localparam int          CNT_W     = $clog2(SCORE_W + 1);
    localparam logic [31:0] MAX_VAL   = 32'(MAX_SCORE);
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0]  SEG_HI_RST = SEG_BLANK;
`else
    localparam logic [6:0]  SEG_HI_RST = SEG_ZERO;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LATCH   = 2'd2
    } state_t;

    state_t             state;
    logic [SCORE_W-1:0] shift_reg;
    logic [15:0]        bcd;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_flag;
    logic               pending;
    logic [15:0]        bcd_adj;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_DASH;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            ovf_flag  <= 1'b0;
            pending   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            hex0      <= SEG_ZERO;
            hex1      <= SEG_HI_RST;
            hex2      <= SEG_HI_RST;
            hex3      <= SEG_HI_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (update || pending) begin
                        shift_reg <= score;
                        bcd       <= '0;
                        bit_cnt   <= CNT_W'(SCORE_W);
                        ovf_flag  <= (32'(score) > MAX_VAL);
                        pending   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (update)
                        pending <= 1'b1;
                    bcd       <= {bcd_adj[14:0], shift_reg[SCORE_W-1]};
                    shift_reg <= {shift_reg[SCORE_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1))
                        state <= LATCH;
                end
                LATCH: begin
                    if (update)
                        pending <= 1'b1;
                    if (ovf_flag) begin
                        overflow <= 1'b1;
                        hex0     <= SEG_DASH;
                        hex1     <= SEG_DASH;
                        hex2     <= SEG_DASH;
                        hex3     <= SEG_DASH;
                    end else begin
                        overflow <= 1'b0;
                        hex0     <= seg7(bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
                        hex3 <= (bcd[15:12] == 4'd0) ? SEG_BLANK : seg7(bcd[15:12]);
                        hex2 <= (bcd[15:8]  == 8'd0) ? SEG_BLANK : seg7(bcd[11:8]);
                        hex1 <= (bcd[15:4]  == 12'd0) ? SEG_BLANK : seg7(bcd[7:4]);
`else
                        hex3 <= seg7(bcd[15:12]);
                        hex2 <= seg7(bcd[11:8]);
                        hex1 <= seg7(bcd[7:4]);
`endif
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_display_controller.sv
// ============================================================================
//  Module   : tb_score_display_controller
//  Function : Directed self-checking bench for score_display_controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_display_controller;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] score;
    logic        update;
    logic        busy, done, overflow;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    int n;

    score_display_controller #(.SCORE_W(14), .MAX_SCORE(9999)) dut (
        .clk(clk), .reset(reset), .score(score), .update(update),
        .busy(busy), .done(done), .overflow(overflow),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
        check({tag, ".hex3"}, int'(hex3), int'(e3));
        check({tag, ".hex2"}, int'(hex2), int'(e2));
        check({tag, ".hex1"}, int'(hex1), int'(e1));
        check({tag, ".hex0"}, int'(hex0), int'(e0));
    endtask

    // Request accepted on the posedge following this call.
    task automatic start(input logic [13:0] s);
        @(negedge clk);
        score  = s;
        update = 1'b1;
        @(posedge clk);
        #1;
        update   = 1'b0;
        busy_cnt = busy ? 1 : 0;
    endtask

    // Counts edges until done is seen; bounded.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (busy) busy_cnt++;
        end while (!done && cnt < 40);
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        reset  = 1'b1;
        update = 1'b0;
        score  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_hex("reset", LZ, LZ, LZ, S0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.ovf", overflow, 0);

        start(14'd1234);
        wait_done(n);
        check("lat1234", n, 15);
        check("busy1234", busy_cnt, 15);
        check_hex("d1234", S1, S2, S3, S4);
        check("ovf1234", overflow, 0);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);

        start(14'd9999);
        wait_done(n);
        check_hex("d9999", S9, S9, S9, S9);
        check("ovf9999", overflow, 0);

        start(14'd0);
        wait_done(n);
        check_hex("d0", LZ, LZ, LZ, S0);

        start(14'd10000);
        wait_done(n);
        check_hex("d10000", SD, SD, SD, SD);
        check("ovf10000", overflow, 1);

        start(14'd5);
        wait_done(n);
        check_hex("d5", LZ, LZ, LZ, S5);
        check("ovf5", overflow, 0);

        // Request arriving mid-conversion must be queued, not lost.
        start(14'd1234);
        repeat (4) @(posedge clk);
        #1;
        score  = 14'd42;
        update = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        wait_done(n);
        check_hex("pend1st", S1, S2, S3, S4);
        wait_done(n);
        check("pend_lat", n, 16);
`ifdef LEADING_ZERO_BLANK_EN
        check_hex("pend2nd", SB, SB, S4, S2);
`else
        check_hex("pend2nd", S0, S0, S4, S2);
`endif

        // Reset during conversion with a pending request queued.
        start(14'd7777);
        repeat (2) @(posedge clk);
        #1;
        update = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_hex("midrst", LZ, LZ, LZ, S0);
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        busy_cnt = 0;
        n = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) n++;
        end
        check("post_rst_busy", busy_cnt, 0);
        check("post_rst_done", n, 0);
        check_hex("post_rst", LZ, LZ, LZ, S0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
